// File: rtl/sisc_pkg.sv
// Shared SISC definitions: datapath widths, zero register and swap sequencer types.
package sisc_pkg;

  localparam int unsigned SISC_DATA_W = 32;
  localparam int unsigned SISC_ADDR_W = 4;

  localparam logic [SISC_ADDR_W-1:0] SISC_ZERO_REG = SISC_ADDR_W'(0);

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_WR_RS = 2'd1,
    SW_WR_RT = 2'd2,
    SW_DONE  = 2'd3
  } swap_state_e;

  // Operands captured on start and replayed during write-back.
  typedef struct packed {
    logic [SISC_ADDR_W-1:0] rs_addr;
    logic [SISC_ADDR_W-1:0] rt_addr;
    logic [SISC_DATA_W-1:0] rs_data;
    logic [SISC_DATA_W-1:0] rt_data;
  } swap_hold_t;

endpackage

// File: rtl/swap_writeback_if.sv
// Control-unit request and register-file write-port signals for the SWAP sequencer.
interface swap_writeback_if;
  import sisc_pkg::*;

  logic                   start;
  logic [SISC_ADDR_W-1:0] rs_addr;
  logic [SISC_ADDR_W-1:0] rt_addr;
  logic [SISC_DATA_W-1:0] rs_data;
  logic [SISC_DATA_W-1:0] rt_data;
  logic                   wr_gnt;
  logic                   rf_wr_en;
  logic [SISC_ADDR_W-1:0] rf_wr_addr;
  logic [SISC_DATA_W-1:0] rf_wr_data;
  logic                   busy;
  logic                   done;

  modport master (
    output start, rs_addr, rt_addr, rs_data, rt_data, wr_gnt,
    input  rf_wr_en, rf_wr_addr, rf_wr_data, busy, done
  );

  modport slave (
    input  start, rs_addr, rt_addr, rs_data, rt_data, wr_gnt,
    output rf_wr_en, rf_wr_addr, rf_wr_data, busy, done
  );

endinterface

// File: rtl/swap_writeback.sv
// SWAP write-back sequencer: writes old rt into rs, then old rs into rt, through
// the arbitrated register-file write port.
module swap_writeback
  import sisc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  swap_writeback_if.slave  bus
);

  swap_state_e            state_q, state_d;
  swap_hold_t             hold_q, hold_d;

  logic                   wr_en_c;
  logic [SISC_ADDR_W-1:0] wr_addr_c;
  logic [SISC_DATA_W-1:0] wr_data_c;
  logic                   busy_c;
  logic                   done_c;

  // Next state, capture and output decode.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wr_en_c   = 1'b0;
    wr_addr_c = SISC_ADDR_W'(0);
    wr_data_c = SISC_DATA_W'(0);
    busy_c    = 1'b0;
    done_c    = 1'b0;

    unique case (state_q)
      SW_IDLE: begin
        if (bus.start) begin
          hold_d.rs_addr = bus.rs_addr;
          hold_d.rt_addr = bus.rt_addr;
          hold_d.rs_data = bus.rs_data;
          hold_d.rt_data = bus.rt_data;
          state_d = (bus.rs_addr == bus.rt_addr) ? SW_DONE : SW_WR_RS;
        end
      end
      SW_WR_RS: begin
        busy_c    = 1'b1;
        wr_addr_c = hold_q.rs_addr;
        wr_data_c = hold_q.rt_data;
        wr_en_c   = (hold_q.rs_addr != SISC_ZERO_REG);
        // R0 is never written, so it needs no grant to move on.
        if (!wr_en_c || bus.wr_gnt) state_d = SW_WR_RT;
      end
      SW_WR_RT: begin
        busy_c    = 1'b1;
        wr_addr_c = hold_q.rt_addr;
        wr_data_c = hold_q.rs_data;
        wr_en_c   = (hold_q.rt_addr != SISC_ZERO_REG);
        if (!wr_en_c || bus.wr_gnt) state_d = SW_DONE;
      end
      SW_DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = SW_IDLE;
      end
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SW_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.rf_wr_en   = wr_en_c;
  assign bus.rf_wr_addr = wr_addr_c;
  assign bus.rf_wr_data = wr_data_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule
